// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//
// Iterative multiply/divide unit that sits behind the register file. It runs
// MULT, MULTU, DIV and DIVU at one bit per cycle and keeps the 64-bit result
// in the architectural HI/LO registers. MTHI/MTLO writes are accepted only
// while the unit is idle.
//
// Handshake: start is sampled only in IDLE. busy is registered and stays high
// from the cycle after start is accepted until the result lands in HI/LO.
// done pulses for one cycle in the first IDLE cycle that shows the new
// HI/LO. A new start may be issued in that same cycle.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      launch an operation (sampled in IDLE only)
//   op         00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//   operand_a  rs value: multiplicand / dividend
//   operand_b  rt value: multiplier / divisor
//   hi_we      MTHI write enable (IDLE, start low)
//   lo_we      MTLO write enable (IDLE, start low)
//   wdata      MTHI/MTLO data
//   busy       operation in progress, pipeline must stall
//   done       one-cycle pulse, hi/lo hold the new result
//   hi         HI register (product upper half / remainder)
//   lo         LO register (product lower half / quotient)
// ---------------------------------------------------------------------------
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] COUNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [CW-1:0]      count;
    logic               is_div;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, remaining dividend / quotient bits}.
    logic [2*WIDTH-1:0] acc;

    // Operand conditioning at start. The magnitude of the most negative value
    // wraps back to itself, which is exactly 2^(WIDTH-1) read as unsigned.
    logic             in_signed;
    logic             in_sign_a;
    logic             in_sign_b;
    logic [WIDTH-1:0] in_mag_a;
    logic [WIDTH-1:0] in_mag_b;

    assign in_signed = ~op[0];
    assign in_sign_a = in_signed & operand_a[WIDTH-1];
    assign in_sign_b = in_signed & operand_b[WIDTH-1];
    assign in_mag_a  = in_sign_a ? -operand_a : operand_a;
    assign in_mag_b  = in_sign_b ? -operand_b : operand_b;

    // One shift-add step: add the multiplicand when the current multiplier
    // bit is set, then shift the whole accumulator right, carry included.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // One restoring-divide step: shift the next dividend bit into the
    // remainder and subtract the divisor; a clear MSB means it fitted.
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_fit;
    logic [2*WIDTH-1:0] div_next;

    assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, mag_b};
    assign div_fit   = ~div_diff[WIDTH];
    assign div_next  = {(div_fit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                        acc[WIDTH-2:0], div_fit};

    // Sign correction applied on the FIXUP edge.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign prod_fix = (sign_a ^ sign_b) ? -acc : acc;
    assign quot     = acc[WIDTH-1:0];
    assign rem      = acc[2*WIDTH-1:WIDTH];

    always_comb begin
        fix_hi = '0;
        fix_lo = '0;
        if (!is_div) begin
            {fix_hi, fix_lo} = prod_fix;
        end else if (mag_b == '0) begin
            // Divide by zero returns the original dividend and all-ones.
            fix_hi = sign_a ? -mag_a : mag_a;
            fix_lo = '1;
        end else begin
            // Truncating division: remainder takes the dividend's sign.
            fix_lo = (sign_a ^ sign_b) ? -quot : quot;
            fix_hi = sign_a ? -rem : rem;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (count == COUNT_LAST) state_next = FIXUP;
            FIXUP:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath, HI/LO and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            is_div <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            mag_a  <= '0;
            mag_b  <= '0;
            acc    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div <= op[1];
                        sign_a <= in_sign_a;
                        sign_b <= in_sign_b;
                        mag_a  <= in_mag_a;
                        mag_b  <= in_mag_b;
                        acc    <= op[1] ? {{WIDTH{1'b0}}, in_mag_a}
                                        : {{WIDTH{1'b0}}, in_mag_b};
                        count  <= '0;
                        busy   <= 1'b1;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                RUN: begin
                    acc   <= is_div ? div_next : mul_next;
                    count <= count + COUNT_ONE;
                end
                FIXUP: begin
                    hi   <= fix_hi;
                    lo   <= fix_lo;
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
//
// Directed bench for mult_div_unit (WIDTH = 32). A table of hand-computed
// {op, a, b, hi, lo} records is run one operation at a time from IDLE, then
// short hand-written sequences cover back-to-back starts, MTHI/MTLO, start
// during RUN and reset in the middle of an operation.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;
    localparam int WIDTH  = 32;
    localparam int BUDGET = 200;
    localparam int NVEC   = 12;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic             clk;
    logic             rst;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    mult_div_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] hi;
        logic [WIDTH-1:0] lo;
    } vec_t;

    vec_t vecs[NVEC];

    int checks_total;
    int checks_passed;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks_total++;
        if (act === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock and sample just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an operation for exactly one edge. Returns 1 time unit after
    // the edge that sampled start (edge E0).
    task automatic start_op(input logic [1:0] o, input logic [WIDTH-1:0] a,
                            input logic [WIDTH-1:0] b);
        start     = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        step();
        start     = 1'b0;
    endtask

    // Called right after start_op. lat = number of edges after E0 until done
    // is seen; busy_cnt = cycles with busy high before that. -1 on timeout.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = -1;
        busy_cnt = 0;
        for (int e = 0; e <= BUDGET; e++) begin
            if (done) begin
                lat = e;
                break;
            end
            if (busy) busy_cnt++;
            step();
        end
    endtask

    initial begin
        int lat;
        int bcnt;
        int pulses;

        checks_total  = 0;
        checks_passed = 0;
        rst       = 1'b1;
        start     = 1'b0;
        op        = 2'b00;
        operand_a = '0;
        operand_b = '0;
        hi_we     = 1'b0;
        lo_we     = 1'b0;
        wdata     = '0;

        // op, a, b, expected hi, expected lo
        vecs[0]  = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[1]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2]  = '{OP_DIVU,  32'd100,       32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
        vecs[3]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[4]  = '{OP_DIVU,  32'd7,         32'd2,         32'd1,         32'd3};
        vecs[5]  = '{OP_MULT,  32'd7,         32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6};
        vecs[6]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[7]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[8]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[9]  = '{OP_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
        vecs[10] = '{OP_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
        vecs[11] = '{OP_DIVU,  32'hFFFF_FFFF, 32'd10,        32'd5,         32'h1999_9999};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hi",   64'(hi),   64'd0);
        check("reset_lo",   64'(lo),   64'd0);

        // Table: each operation from IDLE. done appears after the 33rd edge
        // following the start edge (34th cycle counting the start cycle), with
        // busy high for the 33 cycles before it and low in the done cycle.
        for (int i = 0; i < NVEC; i++) begin
            start_op(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(lat, bcnt);
            check($sformatf("vec%0d_latency", i), 64'(lat),  64'(WIDTH + 1));
            check($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), 64'(WIDTH + 1));
            check($sformatf("vec%0d_busy_at_done", i), 64'(busy), 64'd0);
            check($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].hi));
            check($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].lo));
            step();
            check($sformatf("vec%0d_done_one_cycle", i), 64'(done), 64'd0);
            check($sformatf("vec%0d_hi_hold", i), 64'(hi), 64'(vecs[i].hi));
        end

        // Back-to-back: DIV issued in the cycle done pulses for MULTU.
        start_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, bcnt);
        check("b2b_mul_hi", 64'(hi), 64'hFFFF_FFFE);
        check("b2b_mul_lo", 64'(lo), 64'h0000_0001);
        start_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        check("b2b_accept_busy", 64'(busy), 64'd1);
        check("b2b_hi_held", 64'(hi), 64'hFFFF_FFFE);
        wait_done(lat, bcnt);
        check("b2b_div_latency", 64'(lat), 64'(WIDTH + 1));
        check("b2b_div_hi", 64'(hi), 64'hFFFF_FFFF);
        check("b2b_div_lo", 64'(lo), 64'hFFFF_FFFD);
        step();

        // MTHI / MTLO in IDLE
        hi_we = 1'b1;
        wdata = 32'h1234_5678;
        step();
        hi_we = 1'b0;
        check("mthi_hi", 64'(hi), 64'h1234_5678);
        check("mthi_lo_untouched", 64'(lo), 64'hFFFF_FFFD);
        lo_we = 1'b1;
        wdata = 32'h9ABC_DEF0;
        step();
        lo_we = 1'b0;
        check("mtlo_lo", 64'(lo), 64'h9ABC_DEF0);
        check("mtlo_hi_untouched", 64'(hi), 64'h1234_5678);

        // Write enables in the cycle start is accepted are ignored.
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h5555_AAAA;
        start_op(OP_MULTU, 32'd3, 32'd4);
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("start_prec_hi", 64'(hi), 64'h1234_5678);
        check("start_prec_lo", 64'(lo), 64'h9ABC_DEF0);

        // Write enables while busy are ignored.
        repeat (3) step();
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
        step();
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("busy_we_hi", 64'(hi), 64'h1234_5678);
        check("busy_we_lo", 64'(lo), 64'h9ABC_DEF0);
        wait_done(lat, bcnt);
        check("busy_we_latency", 64'(lat), 64'(WIDTH + 1 - 4));
        check("busy_we_res_hi", 64'(hi), 64'd0);
        check("busy_we_res_lo", 64'(lo), 64'd12);
        step();

        // A second start during RUN is ignored.
        start_op(OP_MULT, 32'hFFFF_FFFD, 32'd5);
        repeat (5) step();
        start     = 1'b1;
        op        = OP_DIVU;
        operand_a = 32'd1;
        operand_b = 32'd1;
        step();
        start = 1'b0;
        wait_done(lat, bcnt);
        check("ignore_start_latency", 64'(lat), 64'(WIDTH + 1 - 6));
        check("ignore_start_hi", 64'(hi), 64'hFFFF_FFFF);
        check("ignore_start_lo", 64'(lo), 64'hFFFF_FFF1);
        step();

        // Reset 10 cycles into a MULTU.
        start_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (9) step();
        check("pre_rst_busy", 64'(busy), 64'd1);
        check("pre_rst_hi_held", 64'(hi), 64'hFFFF_FFFF);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_hi", 64'(hi), 64'd0);
        check("mid_rst_lo", 64'(lo), 64'd0);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) pulses++;
            step();
        end
        check("mid_rst_no_done", 64'(pulses), 64'd0);
        check("mid_rst_lo_still0", 64'(lo), 64'd0);

        start_op(OP_DIVU, 32'd7, 32'd2);
        wait_done(lat, bcnt);
        check("post_rst_latency", 64'(lat), 64'(WIDTH + 1));
        check("post_rst_hi", 64'(hi), 64'd1);
        check("post_rst_lo", 64'(lo), 64'd3);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
